// File: rtl/noc_pkg.sv
// noc_pkg: message layout shared by mesh nodes and the top-level mesh.
// Messages are {ttl, id}; msg_id()/msg_ttl() extract the fields.
package noc_pkg;

    localparam int DATA_W = 8;
    localparam int ID_W   = 5;
    localparam int TTL_W  = DATA_W - ID_W;

    typedef struct packed {
        logic [TTL_W-1:0] ttl;
        logic [ID_W-1:0]  id;
    } msg_t;

    function automatic logic [ID_W-1:0] msg_id(msg_t m);
        return m.id;
    endfunction

    function automatic logic [TTL_W-1:0] msg_ttl(msg_t m);
        return m.ttl;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous valid/ready FIFO, DEPTH a power of two.
// Ports: clk, rstn (async active-low), push/push_data write side with full,
//        out_valid/out_ready/out_data read side, count = occupancy.
// When empty, out_data keeps showing the last entry popped.
module noc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    output logic                     full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  last_q;
    logic          do_push, do_pop;

    assign full      = count == FULL_CNT;
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : last_q;
    assign do_push   = push & ~full;
    assign do_pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/epidemic_ingress_filter.sv
// epidemic_ingress_filter: per-link ingress stage; drops duplicate and
// expired epidemic messages, decrements TTL on survivors and buffers them.
// Ports: clk, rstn (async active-low);
//        in_valid/in_ready/in_data  upstream link, message {ttl,id};
//        out_valid/out_ready/out_data  FIFO head {ttl-1,id} towards node;
//        seen_clr  clears the seen-ID bitmap;
//        drop_dup/drop_ttl  registered one-cycle drop pulses;
//        fifo_count occupancy; dup_cnt/ttl_cnt saturating drop counters.
module epidemic_ingress_filter #(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int ID_W   = noc_pkg::ID_W,
    parameter int TTL_W  = noc_pkg::TTL_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   seen_clr,
    output logic                   drop_dup,
    output logic                   drop_ttl,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       dup_cnt,
    output logic [CNT_W-1:0]       ttl_cnt
);

    logic [ID_W-1:0]      in_id;
    logic [TTL_W-1:0]     in_ttl, ttl_dec;
    logic [2**ID_W-1:0]   seen_q, seen_base, seen_nxt;
    logic                 full, accept, is_dup, ttl_zero, push;

    assign in_id    = in_data[ID_W-1:0];
    assign in_ttl   = in_data[DATA_W-1:ID_W];
    assign ttl_dec  = in_ttl - 1'b1;
    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign ttl_zero = in_ttl == '0;

    // A clear in the accept cycle takes effect before classification, so the
    // accepted ID is judged against an empty map and ends up the only bit set.
    always_comb begin
        seen_base = seen_clr ? '0 : seen_q;
        seen_nxt  = seen_base;
        if (accept) seen_nxt[in_id] = 1'b1;
    end

    assign is_dup = seen_base[in_id];
    assign push   = accept & ~is_dup & ~ttl_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seen_q   <= '0;
            drop_dup <= 1'b0;
            drop_ttl <= 1'b0;
            dup_cnt  <= '0;
            ttl_cnt  <= '0;
        end else begin
            seen_q   <= seen_nxt;
            drop_dup <= accept & is_dup;
            drop_ttl <= accept & ~is_dup & ttl_zero;
            if (accept & is_dup & ~&dup_cnt) dup_cnt <= dup_cnt + 1'b1;
            if (accept & ~is_dup & ttl_zero & ~&ttl_cnt) ttl_cnt <= ttl_cnt + 1'b1;
        end
    end

    noc_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({ttl_dec, in_id}),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_count)
    );

endmodule

// File: doc/epidemic_ingress_filter.md
Name: epidemic_ingress_filter

Overview:
Per-link ingress stage sitting directly upstream of a mesh node's forwarding logic. One instance per node input side (l/r/t/b).
- Accepts 8-bit epidemic messages from the neighbouring node over a valid/ready link.
- Suppresses duplicates with a seen-ID bitmap and drops expired messages (TTL==0).
- Decrements TTL on survivors and buffers them in a small FIFO that the node drains.

Parameters:
DATA_W, 8, message width; fixed layout {ttl[DATA_W-1:ID_W], id[ID_W-1:0]}
ID_W, 5, message-ID field width; seen bitmap holds 2**ID_W bits
TTL_W, 3, TTL field width; must equal DATA_W-ID_W
DEPTH, 4, FIFO depth in messages; power of two, >=2
CNT_W, 8, width of the saturating drop counters

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  upstream message valid
in_ready  output  1  ingress can accept; equals !fifo_full
in_data  input  DATA_W  upstream message {ttl,id}
out_valid  output  1  FIFO head valid towards node
out_ready  input  1  node consumes head
out_data  output  DATA_W  FIFO head {ttl-1,id}
seen_clr  input  1  single-cycle pulse, clears whole seen bitmap
drop_dup  output  1  registered pulse: previous-cycle accept was a duplicate
drop_ttl  output  1  registered pulse: previous-cycle accept had TTL==0
fifo_count  output  $clog2(DEPTH)+1  current occupancy
dup_cnt  output  CNT_W  saturating count of duplicate drops
ttl_cnt  output  CNT_W  saturating count of TTL drops

Behaviour:
- Reset (rstn low, asynchronous): FIFO empty, seen bitmap all 0, counters 0, drop_dup/drop_ttl 0, out_valid 0, out_data 0, fifo_count 0. in_ready is therefore 1 from reset onward.
- Accept = in_valid & in_ready. Classification happens in the same cycle against the current bitmap:
  1. seen[id]==1: discard, drop_dup=1 next cycle, dup_cnt+1 (saturate at all-ones).
  2. else ttl==0: discard, set seen[id], drop_ttl=1 next cycle, ttl_cnt+1 (saturate).
  3. else: push {ttl-1,id} into FIFO, set seen[id].
- Only one of drop_dup / drop_ttl is high in any cycle. Both are 0 when no accept occurred.
- Latency: a pushed message appears at out_valid/out_data on the cycle after accept. There is no same-cycle bypass.
- Back-to-back identical IDs: the bitmap is written on the accept edge, so the second copy is classified as a duplicate.
- seen_clr with a simultaneous accept: the clear applies first, the accepted ID is classified against the cleared map, then its bit is set. The result is only that bit set.
- FIFO: pop = out_valid & out_ready.
  - Full and pop in the same cycle: in_ready stays 0 that cycle, because in_ready is derived from occupancy, not from the pop.
  - Empty: out_valid=0, out_data holds its last value.
  - Push and pop in the same cycle: occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- out_valid and out_data are stable while out_valid & !out_ready (AXI-style hold). in_data is sampled only on accept.
- A discarded message still consumes the accept cycle; in_ready does not depend on the classification.
- Reset mid-operation: all state is lost immediately, including buffered messages and the bitmap. No partial output is emitted after rstn rises.
- TTL arithmetic: TTL_W-bit unsigned; decrement is applied only when ttl>=1, so it never wraps.

Decomposition:
- Shared package noc_pkg:
  - DATA_W, ID_W, TTL_W constants.
  - msg_t packed struct {ttl, id}.
  - Helper functions msg_id() and msg_ttl().
  - The same package serves node and top-level mesh.
- Sub-module noc_fifo: synchronous valid/ready FIFO parameterised by width and DEPTH, exposing count and full. It is reused by node output ports.
- Classification, bitmap and counters live in epidemic_ingress_filter.

Test Plan:
- Reset, then in_data=8'hA3 (ttl=5,id=3) valid one cycle, out_ready=1 -> out_valid next cycle with out_data=8'h83, drop pulses 0, fifo_count 1 then 0.
- Send 8'hA3 twice consecutively -> one FIFO entry 8'h83; drop_dup=1 on cycle after 2nd accept; dup_cnt=1.
- Send 8'h07 (ttl=0,id=7), then 8'h47 -> first gives drop_ttl pulse and ttl_cnt=1; second gives drop_dup (id 7 already seen), no FIFO push.
- out_ready=0, send 5 distinct IDs 1..5 with ttl=2 -> first 4 accepted, in_ready=0 with fifo_count=4; raise out_ready -> data 8'h21,8'h22,8'h23,8'h24 in order, then the 5th is accepted and emitted as 8'h25.
- Send id=9, pulse seen_clr together with a new id=9 message -> the second message is forwarded (not a duplicate); a third id=9 is then a duplicate.
- Drive 300 duplicates of one ID -> dup_cnt saturates at 8'hFF; assert rstn low mid-stream -> all outputs zero, in_ready=1, next id=9 forwarded.
